writeback_control_m: RTL and testbench
======================================

// Module: writeback_control_m
// PURPOSE
//  Sequences the register-file writeback port that is shared by the ALU result path and the
//  load-data path. It drives the MemToReg select of the writeback multiplexer, plus regWrite and
//  regWriteAddr, and tracks one outstanding variable-latency load.
//  It arbitrates ALU vs. memory writebacks, stalls the ALU on a destination conflict, and
//  times out lost loads. It sits between decode/execute control and the writeback mux/register file.
// PARAMETERS
//  REG_ADDR_W   5    register address width
//  MEM_TIMEOUT  15   max cycles in LOAD_WAIT before abort (>=2)
//  CNT_W        4    timeout counter width, clog2(MEM_TIMEOUT+1)
// PORTS
//  clk            in   1           single clock; all state updates on posedge
//  rst_n          in   1           synchronous, active-low reset
//  aluValid       in   1           ALU result ready for writeback this cycle
//  aluDest        in   REG_ADDR_W  ALU destination register
//  memReqValid    in   1           load issued; hold until memReqReady
//  memReqDest     in   REG_ADDR_W  load destination register
//  memReqReady    out  1           load accepted this cycle (comb.)
//  memRespValid   in   1           load data present at mux memory input this cycle
//  stall          out  1           ALU writeback refused; hold aluValid/aluDest (comb.)
//  memToReg       out  1           mux select: 1 = memory data, 0 = ALU result (registered)
//  regWrite       out  1           register-file write enable (registered)
//  regWriteAddr   out  REG_ADDR_W  register-file write address (registered)
//  loadPending    out  1           1 while in LOAD_WAIT (registered)
//  timeoutErr     out  1           sticky; set on load timeout, cleared only by reset
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): state=IDLE, pendDest=0, counter=0; every registered output=0.
//    Reset mid-load drops the pending load. Any later memRespValid is ignored.
//  - States: IDLE, LOAD_WAIT. memReqReady = (state==IDLE).
//  - IDLE: memReqValid -> latch pendDest=memReqDest, counter=0, go to LOAD_WAIT.
//    An ALU write in the same cycle is still accepted. memRespValid in IDLE is ignored.
//  - LOAD_WAIT with memRespValid: next cycle regWrite=1, memToReg=1, regWriteAddr=pendDest.
//    Go to IDLE. A same-cycle aluValid gets stall=1 (memory has priority).
//  - LOAD_WAIT without memRespValid: counter++.
//    When counter==MEM_TIMEOUT-1 with no response: set timeoutErr, go to IDLE, no write.
//  - ALU path, accepted when aluValid && !stall: next cycle regWrite=1, memToReg=0,
//    regWriteAddr=aluDest.
//  - WAW hazard: in LOAD_WAIT, aluValid && aluDest==pendDest && aluDest!=0 -> stall=1.
//  - stall = aluValid && state==LOAD_WAIT && (memRespValid || (aluDest==pendDest && aluDest!=0)).
//  - Register 0: any write targeting address 0 yields regWrite=0 next cycle.
//    memToReg still follows the selected source.
//  - Cycles with no accepted write: regWrite=0, memToReg=0, regWriteAddr holds last value.
//  - Latency: one cycle from accepted event to regWrite. The datapath registers the ALU result
//    and memory data one stage, so the select aligns with the data at the mux.
//  - At most one load outstanding. A second memReqValid waits (memReqReady=0) until IDLE.
// STRUCTURE
//  - Shared package: state encoding constants (ST_IDLE=1'b0, ST_LOAD_WAIT=1'b1) and
//    REG_ZERO=5'd0. The ALU-stage stall logic also uses REG_ZERO.
//  - One natural sub-module: wb_timeout_counter_m (clear, enable, terminal-count flag).
//    The FSM, hazard compare and output registers stay in this module.
// TESTING
//  - ALU only: aluValid=1, aluDest=7 for 3 cycles -> regWrite=1, memToReg=0,
//    regWriteAddr=7 each following cycle; stall=0.
//  - Load: memReqValid, dest=9, then memRespValid 4 cycles later -> one cycle regWrite=1,
//    memToReg=1, addr=9; memReqReady=0 in between.
//  - Collision: memRespValid and aluValid (dest=3) in the same cycle -> stall=1, memory write first.
//    The ALU write to 3 lands the cycle after.
//  - WAW: load to 9 pending, aluValid dest=9 -> stall held until response.
//    The memory write to 9 occurs first, then the ALU write to 9.
//  - Timeout: load issued, no response for MEM_TIMEOUT cycles -> timeoutErr=1, back to IDLE,
//    no write. A late memRespValid is ignored.
//  - Reset mid-load and reg 0: rst_n=0 during LOAD_WAIT -> all outputs 0, memReqReady=1.
//    An ALU write to dest 0 gives regWrite=0.

Source files
------------

// File: rtl/writeback_control_m_pkg.sv
// Shared definitions for the writeback control block.
//   wb_state_e : controller state encoding (IDLE / LOAD_WAIT)
//   REG_ZERO   : hardwired-zero register address; writes to it are dropped
package writeback_control_m_pkg;

  typedef enum logic {
    ST_IDLE      = 1'b0,
    ST_LOAD_WAIT = 1'b1
  } wb_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/writeback_control_m_if.sv
// Writeback control bus: groups the ALU, load request/response and
// register-file writeback signals.
//   master : decode/execute + testbench side (drives requests, observes writeback)
//   slave  : writeback_control_m side
interface writeback_control_m_if #(
  parameter int REG_ADDR_W = 5
);
  logic                  aluValid;
  logic [REG_ADDR_W-1:0] aluDest;
  logic                  memReqValid;
  logic [REG_ADDR_W-1:0] memReqDest;
  logic                  memReqReady;
  logic                  memRespValid;
  logic                  stall;
  logic                  memToReg;
  logic                  regWrite;
  logic [REG_ADDR_W-1:0] regWriteAddr;
  logic                  loadPending;
  logic                  timeoutErr;

  modport master (
    output aluValid, aluDest, memReqValid, memReqDest, memRespValid,
    input  memReqReady, stall, memToReg, regWrite, regWriteAddr,
           loadPending, timeoutErr
  );

  modport slave (
    input  aluValid, aluDest, memReqValid, memReqDest, memRespValid,
    output memReqReady, stall, memToReg, regWrite, regWriteAddr,
           loadPending, timeoutErr
  );
endinterface

// File: rtl/writeback_control_m_timeout.sv
// Load timeout counter.
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : restart count at 0 (takes priority over en)
//   en         : count up by one
//   tc         : count has reached MEM_TIMEOUT-1
module wb_timeout_counter_m #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tc = (cnt_q == CNT_W'(MEM_TIMEOUT - 1));
endmodule

// File: rtl/writeback_control_m.sv
// Writeback port sequencer shared by the ALU result path and the load path.
// Tracks one outstanding load, gives memory priority over the ALU, stalls the
// ALU on a WAW conflict with the pending load, and aborts lost loads.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : writeback_control_m_if.slave (requests in, writeback controls out)
module writeback_control_m
  import writeback_control_m_pkg::*;
#(
  parameter int REG_ADDR_W  = 5,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  writeback_control_m_if.slave bus
);
  localparam logic [REG_ADDR_W-1:0] ZERO = REG_ADDR_W'(REG_ZERO);

  wb_state_e             state_q, state_d;
  logic [REG_ADDR_W-1:0] pend_dest_q, pend_dest_d;
  logic [REG_ADDR_W-1:0] reg_write_addr_q, reg_write_addr_d;
  logic                  reg_write_q, reg_write_d;
  logic                  mem_to_reg_q, mem_to_reg_d;
  logic                  timeout_err_q, timeout_err_d;
  logic                  cnt_clr, cnt_en, cnt_tc;
  logic                  in_wait, waw_hit, stall;

  wb_timeout_counter_m #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) u_tmo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .tc    (cnt_tc)
  );

  assign in_wait = (state_q == ST_LOAD_WAIT);
  // Register 0 never holds a result, so it cannot create a WAW conflict.
  assign waw_hit = (bus.aluDest == pend_dest_q) && (bus.aluDest != ZERO);
  assign stall   = bus.aluValid && in_wait && (bus.memRespValid || waw_hit);

  always_comb begin
    state_d          = state_q;
    pend_dest_d      = pend_dest_q;
    reg_write_d      = 1'b0;
    mem_to_reg_d     = 1'b0;
    reg_write_addr_d = reg_write_addr_q;
    timeout_err_d    = timeout_err_q;
    cnt_clr          = 1'b0;
    cnt_en           = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.memReqValid) begin
          pend_dest_d = bus.memReqDest;
          cnt_clr     = 1'b1;
          state_d     = ST_LOAD_WAIT;
        end
      end
      ST_LOAD_WAIT: begin
        if (bus.memRespValid) begin
          reg_write_d      = (pend_dest_q != ZERO);
          mem_to_reg_d     = 1'b1;
          reg_write_addr_d = pend_dest_q;
          state_d          = ST_IDLE;
        end else if (cnt_tc) begin
          timeout_err_d = 1'b1;
          state_d       = ST_IDLE;
        end else begin
          cnt_en = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A memory write always stalls the ALU, so the two never collide here.
    if (bus.aluValid && !stall) begin
      reg_write_d      = (bus.aluDest != ZERO);
      mem_to_reg_d     = 1'b0;
      reg_write_addr_d = bus.aluDest;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= ST_IDLE;
      pend_dest_q      <= '0;
      reg_write_q      <= 1'b0;
      mem_to_reg_q     <= 1'b0;
      reg_write_addr_q <= '0;
      timeout_err_q    <= 1'b0;
    end else begin
      state_q          <= state_d;
      pend_dest_q      <= pend_dest_d;
      reg_write_q      <= reg_write_d;
      mem_to_reg_q     <= mem_to_reg_d;
      reg_write_addr_q <= reg_write_addr_d;
      timeout_err_q    <= timeout_err_d;
    end
  end

  assign bus.memReqReady  = (state_q == ST_IDLE);
  assign bus.stall        = stall;
  assign bus.regWrite     = reg_write_q;
  assign bus.memToReg     = mem_to_reg_q;
  assign bus.regWriteAddr = reg_write_addr_q;
  assign bus.loadPending  = in_wait;
  assign bus.timeoutErr   = timeout_err_q;
endmodule

// File: tb/tb_writeback_control_m.sv
module tb_writeback_control_m;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  writeback_control_m_if #(.REG_ADDR_W(AW)) bus ();

  writeback_control_m #(.REG_ADDR_W(AW), .MEM_TIMEOUT(15), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic          alu_v;
    logic [AW-1:0] alu_d;
    logic          req_v;
    logic [AW-1:0] req_d;
    logic          resp_v;
    logic          e_rdy;
    logic          e_stall;
    logic          e_rw;
    logic          e_m2r;
    logic [AW-1:0] e_addr;
    logic          e_lp;
  } vec_t;

  int errors = 0;
  int checks = 0;
  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic av, input int ad, input logic rv, input int rd,
                              input logic sv, input logic rdy, input logic st,
                              input logic rw, input logic m2r, input int addr, input logic lp);
    vec_t v;
    v.alu_v = av; v.alu_d = AW'(ad); v.req_v = rv; v.req_d = AW'(rd); v.resp_v = sv;
    v.e_rdy = rdy; v.e_stall = st; v.e_rw = rw; v.e_m2r = m2r; v.e_addr = AW'(addr); v.e_lp = lp;
    return v;
  endfunction

  task automatic drive(input logic av, input int ad, input logic rv, input int rd, input logic sv);
    bus.aluValid = av; bus.aluDest = AW'(ad);
    bus.memReqValid = rv; bus.memReqDest = AW'(rd);
    bus.memRespValid = sv;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0);
    rst_n = 1'b0;
    tick(); tick();
    // Reset state
    chk("rst_regWrite", int'(bus.regWrite), 0);
    chk("rst_memToReg", int'(bus.memToReg), 0);
    chk("rst_addr", int'(bus.regWriteAddr), 0);
    chk("rst_loadPending", int'(bus.loadPending), 0);
    chk("rst_timeoutErr", int'(bus.timeoutErr), 0);
    chk("rst_ready", int'(bus.memReqReady), 1);
    rst_n = 1'b1;

    //          alu    req    resp rdy st  | rw m2r addr lp
    // ALU only, dest 7
    vecs.push_back(mk(1,7, 0,0, 0, 1,0, 1,0,7,0));
    vecs.push_back(mk(1,7, 0,0, 0, 1,0, 1,0,7,0));
    vecs.push_back(mk(1,7, 0,0, 0, 1,0, 1,0,7,0));
    vecs.push_back(mk(0,0, 0,0, 0, 1,0, 0,0,7,0));
    // Load to 9, response 4 cycles later; a second request waits meanwhile
    vecs.push_back(mk(0,0, 1,9, 0, 1,0, 0,0,7,1));
    vecs.push_back(mk(0,0, 1,5, 0, 0,0, 0,0,7,1));
    vecs.push_back(mk(0,0, 1,5, 0, 0,0, 0,0,7,1));
    vecs.push_back(mk(0,0, 1,5, 0, 0,0, 0,0,7,1));
    vecs.push_back(mk(0,0, 0,0, 1, 0,0, 1,1,9,0));
    vecs.push_back(mk(0,0, 0,0, 0, 1,0, 0,0,9,0));
    // Collision: response and ALU dest 3 together, ALU lands one cycle later
    vecs.push_back(mk(0,0, 1,4, 0, 1,0, 0,0,9,1));
    vecs.push_back(mk(1,3, 0,0, 1, 0,1, 1,1,4,0));
    vecs.push_back(mk(1,3, 0,0, 0, 1,0, 1,0,3,0));
    // WAW on 9: ALU stalled until the load writes
    vecs.push_back(mk(0,0, 1,9, 0, 1,0, 0,0,3,1));
    vecs.push_back(mk(1,9, 0,0, 0, 0,1, 0,0,3,1));
    vecs.push_back(mk(1,9, 0,0, 0, 0,1, 0,0,3,1));
    vecs.push_back(mk(1,9, 0,0, 1, 0,1, 1,1,9,0));
    vecs.push_back(mk(1,9, 0,0, 0, 1,0, 1,0,9,0));
    // ALU accepted with issue in IDLE and to non-conflicting dests while waiting
    vecs.push_back(mk(1,2, 1,6, 0, 1,0, 1,0,2,1));
    vecs.push_back(mk(1,8, 0,0, 0, 0,0, 1,0,8,1));
    vecs.push_back(mk(1,0, 0,0, 0, 0,0, 0,0,0,1));
    vecs.push_back(mk(0,0, 0,0, 1, 0,0, 1,1,6,0));
    // Response in IDLE is ignored
    vecs.push_back(mk(0,0, 0,0, 1, 1,0, 0,0,6,0));
    // Load to register 0: no write, select still memory
    vecs.push_back(mk(0,0, 1,0, 0, 1,0, 0,0,6,1));
    vecs.push_back(mk(0,0, 0,0, 1, 0,0, 0,1,0,0));

    foreach (vecs[i]) begin
      drive(vecs[i].alu_v, int'(vecs[i].alu_d), vecs[i].req_v, int'(vecs[i].req_d), vecs[i].resp_v);
      #1;
      chk($sformatf("v%0d_ready", i), int'(bus.memReqReady), int'(vecs[i].e_rdy));
      chk($sformatf("v%0d_stall", i), int'(bus.stall), int'(vecs[i].e_stall));
      tick();
      chk($sformatf("v%0d_regWrite", i), int'(bus.regWrite), int'(vecs[i].e_rw));
      chk($sformatf("v%0d_memToReg", i), int'(bus.memToReg), int'(vecs[i].e_m2r));
      chk($sformatf("v%0d_addr", i), int'(bus.regWriteAddr), int'(vecs[i].e_addr));
      chk($sformatf("v%0d_loadPending", i), int'(bus.loadPending), int'(vecs[i].e_lp));
      chk($sformatf("v%0d_timeoutErr", i), int'(bus.timeoutErr), 0);
    end

    // Timeout: 15 cycles in LOAD_WAIT with no response
    drive(0, 0, 1, 11, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    for (int k = 0; k < 14; k++) tick();
    chk("tmo_still_pending", int'(bus.loadPending), 1);
    chk("tmo_err_not_yet", int'(bus.timeoutErr), 0);
    tick();
    chk("tmo_pending_cleared", int'(bus.loadPending), 0);
    chk("tmo_err_set", int'(bus.timeoutErr), 1);
    chk("tmo_no_write", int'(bus.regWrite), 0);
    chk("tmo_ready", int'(bus.memReqReady), 1);
    drive(0, 0, 0, 0, 1);
    tick();
    drive(0, 0, 0, 0, 0);
    chk("tmo_late_resp_rw", int'(bus.regWrite), 0);
    chk("tmo_late_resp_m2r", int'(bus.memToReg), 0);
    tick();
    chk("tmo_err_sticky", int'(bus.timeoutErr), 1);

    // Reset in the middle of a load
    drive(1, 4, 1, 12, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    tick(); tick();
    chk("mid_pending", int'(bus.loadPending), 1);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_regWrite", int'(bus.regWrite), 0);
    chk("mid_rst_memToReg", int'(bus.memToReg), 0);
    chk("mid_rst_addr", int'(bus.regWriteAddr), 0);
    chk("mid_rst_loadPending", int'(bus.loadPending), 0);
    chk("mid_rst_timeoutErr", int'(bus.timeoutErr), 0);
    chk("mid_rst_ready", int'(bus.memReqReady), 1);
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 1);
    tick();
    chk("mid_late_resp_rw", int'(bus.regWrite), 0);
    chk("mid_late_resp_m2r", int'(bus.memToReg), 0);
    drive(1, 0, 0, 0, 0);
    #1;
    chk("r0_stall", int'(bus.stall), 0);
    tick();
    chk("r0_regWrite", int'(bus.regWrite), 0);
    chk("r0_memToReg", int'(bus.memToReg), 0);
    drive(1, 12, 0, 0, 0);
    tick();
    chk("after_r0_regWrite", int'(bus.regWrite), 1);
    chk("after_r0_addr", int'(bus.regWriteAddr), 12);
    drive(0, 0, 0, 0, 0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
